// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter : 6-way round-robin arbiter/mux with burst ownership
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_mux_arbiter #(
  parameter int BURST = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] req,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [3:0] data2,
  input  logic [3:0] data3,
  input  logic [3:0] data4,
  input  logic [3:0] data5,
  output logic [5:0] gnt,
  output logic [3:0] out,
  output logic [2:0] out_sel,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  localparam logic [3:0] c_burst = 4'(BURST);

  function automatic logic [2:0] inc_mod6(input logic [2:0] a);
    return (a == 3'd5) ? 3'd0 : a + 3'd1;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] out_q, out_d;
  logic [2:0] out_sel_q, out_sel_d;
  logic       out_valid_q, out_valid_d;

  logic       w_load;
  logic       w_found;
  logic [2:0] w_win;
  logic [2:0] w_idx;
  logic [3:0] w_data;
  logic [3:0] w_n;

  assign w_load = !out_valid_q || out_ready;

  // Cyclic search from ptr; an owner still requesting overrides the search.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = ptr_q;
    for (int k = 0; k < 6; k++) begin
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = inc_mod6(w_idx);
    end
    if (state_q == S_OWN && req[owner_q]) begin
      w_found = 1'b1;
      w_win   = owner_q;
    end
  end

  always_comb begin
    case (w_win)
      3'd0:    w_data = data0;
      3'd1:    w_data = data1;
      3'd2:    w_data = data2;
      3'd3:    w_data = data3;
      3'd4:    w_data = data4;
      3'd5:    w_data = data5;
      default: w_data = data0;
    endcase
  end

  assign w_n = (state_q == S_OWN && w_win == owner_q) ? cnt_q + 4'd1 : 4'd1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    gnt         = 6'd0;
    if (w_load) begin
      if (w_found) begin
        gnt         = reset ? 6'd0 : (6'd1 << w_win);
        out_d       = w_data;
        out_sel_d   = w_win;
        out_valid_d = 1'b1;
        ptr_d       = inc_mod6(w_win);
        if (w_n >= c_burst) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_OWN;
          owner_d = w_win;
          cnt_d   = w_n;
        end
      end else begin
        // ptr already equals owner+1, so dropping to IDLE resumes after the owner.
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
        cnt_d       = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 3'd0;
      cnt_q       <= 4'd0;
      ptr_q       <= 3'd0;
      out_q       <= 4'd0;
      out_sel_q   <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire
